// File: rtl/picorv32_pcpi_div.sv
// Iterative RV32M divider (DIV/DIVU/REM/REMU) on the PCPI bus, one restoring step per cycle.
// Optional macro PCPI_DIV_FASTZERO_EN: a zero divisor bypasses the iteration and completes immediately.
module picorv32_pcpi_div #(
  parameter int ENABLE_REM = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        pcpi_valid,
  input  logic [31:0] pcpi_insn,
  input  logic [31:0] pcpi_rs1,
  input  logic [31:0] pcpi_rs2,
  output logic        pcpi_wr,
  output logic [31:0] pcpi_rd,
  output logic        pcpi_wait,
  output logic        pcpi_ready
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t      state_q, state_d;
  logic [4:0]  count_q, count_d;
  logic [31:0] divisor_q, divisor_d;
  logic [63:0] rem_q, rem_d;
  logic [31:0] quo_q, quo_d;
  logic        is_rem_q, is_rem_d;
  logic        neg_q, neg_d;
  logic        zero_q, zero_d;
  logic        ready_q, ready_d;
  logic        wr_q, wr_d;
  logic        wait_q, wait_d;
  logic [31:0] rd_q, rd_d;

  logic        insn_match;
  logic        signed_op;
  logic        s1, s2;
  logic [31:0] mag1, mag2;
  logic        step_ge;
  logic [31:0] step_hi;
  logic [31:0] quo_fix, rem_fix, result;
  logic        unused_insn_bits;

  assign insn_match = (pcpi_insn[6:0] == 7'b0110011) && (pcpi_insn[31:25] == 7'b0000001) &&
                      pcpi_insn[14] && ((ENABLE_REM != 0) || !pcpi_insn[13]);
  assign unused_insn_bits = ^{pcpi_insn[24:15], pcpi_insn[11:7]};

  assign signed_op = !pcpi_insn[12];
  assign s1   = signed_op & pcpi_rs1[31];
  assign s2   = signed_op & pcpi_rs2[31];
  assign mag1 = s1 ? (~pcpi_rs1 + 32'd1) : pcpi_rs1;
  assign mag2 = s2 ? (~pcpi_rs2 + 32'd1) : pcpi_rs2;

  // Shifted partial remainder is 33 bits wide; a successful subtract always fits back in 32.
  assign step_ge = rem_q[63:31] >= {1'b0, divisor_q};
  assign step_hi = step_ge ? (rem_q[62:31] - divisor_q) : rem_q[62:31];

  assign quo_fix = zero_q ? 32'hFFFF_FFFF : (neg_q ? (~quo_q + 32'd1) : quo_q);
  assign rem_fix = neg_q ? (~rem_q[63:32] + 32'd1) : rem_q[63:32];
  assign result  = is_rem_q ? rem_fix : quo_fix;

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    divisor_d = divisor_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    is_rem_d  = is_rem_q;
    neg_d     = neg_q;
    zero_d    = zero_q;
    wait_d    = wait_q;
    ready_d   = 1'b0;
    wr_d      = 1'b0;
    rd_d      = 32'h0;

    case (state_q)
      IDLE: begin
        wait_d = 1'b0;
        // ready_q still high means the core has not yet seen its result; do not re-accept.
        if (pcpi_valid && insn_match && !ready_q) begin
          divisor_d = mag2;
          rem_d     = {32'h0, mag1};
          quo_d     = 32'h0;
          is_rem_d  = pcpi_insn[13];
          neg_d     = pcpi_insn[13] ? s1 : (s1 ^ s2);
          zero_d    = (pcpi_rs2 == 32'h0);
          count_d   = 5'd0;
          wait_d    = 1'b1;
`ifdef PCPI_DIV_FASTZERO_EN
          if (pcpi_rs2 == 32'h0) begin
            state_d = DONE;
            rem_d   = {mag1, 32'h0};
            quo_d   = 32'hFFFF_FFFF;
          end else begin
            state_d = BUSY;
          end
`else
          state_d = BUSY;
`endif
        end
      end
      BUSY: begin
        if (!pcpi_valid) begin
          state_d = IDLE;
          wait_d  = 1'b0;
        end else begin
          rem_d = {step_hi, rem_q[30:0], 1'b0};
          quo_d = {quo_q[30:0], step_ge};
          if (count_q == 5'd31) begin
            state_d = DONE;
          end else begin
            count_d = count_q + 5'd1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        wait_d  = 1'b0;
        if (pcpi_valid) begin
          ready_d = 1'b1;
          wr_d    = 1'b1;
          rd_d    = result;
        end
      end
      default: begin
        state_d = IDLE;
        wait_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= IDLE;
      count_q   <= 5'd0;
      divisor_q <= 32'h0;
      rem_q     <= 64'h0;
      quo_q     <= 32'h0;
      is_rem_q  <= 1'b0;
      neg_q     <= 1'b0;
      zero_q    <= 1'b0;
      ready_q   <= 1'b0;
      wr_q      <= 1'b0;
      wait_q    <= 1'b0;
      rd_q      <= 32'h0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      divisor_q <= divisor_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      is_rem_q  <= is_rem_d;
      neg_q     <= neg_d;
      zero_q    <= zero_d;
      ready_q   <= ready_d;
      wr_q      <= wr_d;
      wait_q    <= wait_d;
      rd_q      <= rd_d;
    end
  end

  assign pcpi_ready = ready_q;
  assign pcpi_wr    = wr_q;
  assign pcpi_wait  = wait_q;
  assign pcpi_rd    = rd_q;

endmodule

// File: tb/tb_picorv32_pcpi_div.sv
// Directed bench for picorv32_pcpi_div: results, latency, divide-by-zero, overflow, decode, abort, reset.
// Expected zero-divisor latency follows PCPI_DIV_FASTZERO_EN when it is defined for the build.
module tb_picorv32_pcpi_div;

  logic        clk = 1'b0;
  logic        resetn;
  logic        pcpi_valid;
  logic [31:0] pcpi_insn;
  logic [31:0] pcpi_rs1;
  logic [31:0] pcpi_rs2;
  logic        pcpi_wr;
  logic [31:0] pcpi_rd;
  logic        pcpi_wait;
  logic        pcpi_ready;
  logic        n_wr;
  logic [31:0] n_rd;
  logic        n_wait;
  logic        n_ready;

  int checks = 0;
  int errors = 0;

`ifdef PCPI_DIV_FASTZERO_EN
  localparam int ZeroLat = 1;
`else
  localparam int ZeroLat = 33;
`endif

  localparam logic [2:0] F_DIV = 3'b100, F_DIVU = 3'b101, F_REM = 3'b110, F_REMU = 3'b111;

  always #5 clk = ~clk;

  picorv32_pcpi_div #(.ENABLE_REM(1)) dut (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(pcpi_wr), .pcpi_rd(pcpi_rd),
    .pcpi_wait(pcpi_wait), .pcpi_ready(pcpi_ready)
  );

  picorv32_pcpi_div #(.ENABLE_REM(0)) dut_norem (
    .clk(clk), .resetn(resetn), .pcpi_valid(pcpi_valid), .pcpi_insn(pcpi_insn),
    .pcpi_rs1(pcpi_rs1), .pcpi_rs2(pcpi_rs2), .pcpi_wr(n_wr), .pcpi_rd(n_rd),
    .pcpi_wait(n_wait), .pcpi_ready(n_ready)
  );

  function automatic logic [31:0] mk_insn(input logic [6:0] funct7, input logic [2:0] funct3);
    return {funct7, 5'd2, 5'd1, funct3, 5'd3, 7'b0110011};
  endfunction

  // Offer one instruction and follow it until ready or a 60-cycle budget runs out (k_ready = -1).
  task automatic do_op(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] rd, output int k_ready, output int wait_cnt,
                       output logic wr, output logic wait_at_ready);
    @(negedge clk);
    pcpi_insn = insn; pcpi_rs1 = a; pcpi_rs2 = b; pcpi_valid = 1'b1;
    k_ready = -1; wait_cnt = 0; rd = 32'h0; wr = 1'b0; wait_at_ready = 1'b1;
    for (int k = 0; k < 60; k++) begin
      @(posedge clk); @(negedge clk);
      if (pcpi_wait) wait_cnt++;
      if (pcpi_ready) begin
        k_ready = k; rd = pcpi_rd; wr = pcpi_wr; wait_at_ready = pcpi_wait;
        break;
      end
    end
    pcpi_valid = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; pcpi_valid = 1'b0; pcpi_insn = 32'h0; pcpi_rs1 = 32'h0; pcpi_rs2 = 32'h0;
    repeat (3) @(negedge clk);
    checks++; if (pcpi_wait !== 1'b0) begin errors++; $display("[TB] FAIL reset_wait got %b want 0", pcpi_wait); end
    checks++; if (pcpi_ready !== 1'b0) begin errors++; $display("[TB] FAIL reset_ready got %b want 0", pcpi_ready); end
    checks++; if (pcpi_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_wr got %b want 0", pcpi_wr); end
    checks++; if (pcpi_rd !== 32'h0) begin errors++; $display("[TB] FAIL reset_rd got %h want 0", pcpi_rd); end
    resetn = 1'b1;
  endtask

  task automatic test_signed();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    do_op(mk_insn(7'b0000001, F_DIV), 32'd7, 32'hFFFF_FFFE, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_7_m2 got %h want fffffffd", rd); end
    checks++; if (k !== 33) begin errors++; $display("[TB] FAIL div_latency got %0d want 33", k); end
    checks++; if (w !== 33) begin errors++; $display("[TB] FAIL div_wait_cycles got %0d want 33", w); end
    checks++; if (wr !== 1'b1) begin errors++; $display("[TB] FAIL div_wr got %b want 1", wr); end
    checks++; if (wr_wait !== 1'b0) begin errors++; $display("[TB] FAIL div_wait_at_ready got %b want 0", wr_wait); end
    @(negedge clk);
    checks++; if (pcpi_ready !== 1'b0 || pcpi_rd !== 32'h0) begin
      errors++; $display("[TB] FAIL ready_pulse got ready=%b rd=%h want 0/0", pcpi_ready, pcpi_rd);
    end
    do_op(mk_insn(7'b0000001, F_REM), 32'd7, 32'hFFFF_FFFE, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'd1) begin errors++; $display("[TB] FAIL rem_7_m2 got %h want 1", rd); end
    do_op(mk_insn(7'b0000001, F_DIV), 32'hFFFF_FFF9, 32'd2, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFD) begin errors++; $display("[TB] FAIL div_m7_2 got %h want fffffffd", rd); end
    do_op(mk_insn(7'b0000001, F_REM), 32'hFFFF_FFF9, 32'd2, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL rem_m7_2 got %h want ffffffff", rd); end
  endtask

  task automatic test_unsigned();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    do_op(mk_insn(7'b0000001, F_REMU), 32'hFFFF_FFFF, 32'h10, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hF) begin errors++; $display("[TB] FAIL remu_ffffffff_16 got %h want f", rd); end
    do_op(mk_insn(7'b0000001, F_DIVU), 32'hFFFF_FFFF, 32'h10, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'h0FFF_FFFF) begin errors++; $display("[TB] FAIL divu_ffffffff_16 got %h want 0fffffff", rd); end
    do_op(mk_insn(7'b0000001, F_DIVU), 32'h8000_0001, 32'hFFFF_FFFF, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL divu_big_divisor got %h want 0", rd); end
  endtask

  task automatic test_div_zero();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    do_op(mk_insn(7'b0000001, F_DIV), 32'd5, 32'd0, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_5_0 got %h want ffffffff", rd); end
    checks++; if (k !== ZeroLat) begin errors++; $display("[TB] FAIL div0_latency got %0d want %0d", k, ZeroLat); end
    checks++; if (w !== ZeroLat) begin errors++; $display("[TB] FAIL div0_wait_cycles got %0d want %0d", w, ZeroLat); end
    do_op(mk_insn(7'b0000001, F_DIV), 32'hFFFF_FFFB, 32'd0, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL div_m5_0 got %h want ffffffff", rd); end
    do_op(mk_insn(7'b0000001, F_REM), 32'd5, 32'd0, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'd5) begin errors++; $display("[TB] FAIL rem_5_0 got %h want 5", rd); end
    do_op(mk_insn(7'b0000001, F_REM), 32'hFFFF_FFFB, 32'd0, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFB) begin errors++; $display("[TB] FAIL rem_m5_0 got %h want fffffffb", rd); end
    do_op(mk_insn(7'b0000001, F_DIVU), 32'd9, 32'd0, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFFF) begin errors++; $display("[TB] FAIL divu_9_0 got %h want ffffffff", rd); end
  endtask

  task automatic test_overflow();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    do_op(mk_insn(7'b0000001, F_DIV), 32'h8000_0000, 32'hFFFF_FFFF, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'h8000_0000) begin errors++; $display("[TB] FAIL div_overflow got %h want 80000000", rd); end
    do_op(mk_insn(7'b0000001, F_REM), 32'h8000_0000, 32'hFFFF_FFFF, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'h0) begin errors++; $display("[TB] FAIL rem_overflow got %h want 0", rd); end
  endtask

  task automatic test_no_match();
    int active;
    @(negedge clk);
    pcpi_insn = mk_insn(7'b0000001, 3'b000); pcpi_rs1 = 32'd6; pcpi_rs2 = 32'd3; pcpi_valid = 1'b1;
    active = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (pcpi_wait || pcpi_ready || pcpi_wr) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("[TB] FAIL mul_ignored got %0d active cycles want 0", active); end
    pcpi_insn = mk_insn(7'b0000001, F_REM);
    active = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (n_wait || n_ready || n_wr) active++;
    end
    checks++; if (active !== 0) begin errors++; $display("[TB] FAIL norem_rem_ignored got %0d active cycles want 0", active); end
    pcpi_valid = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_abort();
    int seen;
    @(negedge clk);
    pcpi_insn = mk_insn(7'b0000001, F_DIVU); pcpi_rs1 = 32'd1000; pcpi_rs2 = 32'd3; pcpi_valid = 1'b1;
    repeat (10) begin @(posedge clk); @(negedge clk); end
    pcpi_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (pcpi_wait !== 1'b0) begin errors++; $display("[TB] FAIL abort_wait got %b want 0", pcpi_wait); end
    seen = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (pcpi_ready || pcpi_wr) seen++;
    end
    checks++; if (seen !== 0) begin errors++; $display("[TB] FAIL abort_no_ready got %0d pulses want 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    @(negedge clk);
    pcpi_insn = mk_insn(7'b0000001, F_DIV); pcpi_rs1 = 32'd12345; pcpi_rs2 = 32'd7; pcpi_valid = 1'b1;
    repeat (20) begin @(posedge clk); @(negedge clk); end
    checks++; if (pcpi_wait !== 1'b1) begin errors++; $display("[TB] FAIL busy_before_reset got %b want 1", pcpi_wait); end
    resetn = 1'b0;
    #1;
    checks++; if (pcpi_wait !== 1'b0 || pcpi_ready !== 1'b0 || pcpi_wr !== 1'b0 || pcpi_rd !== 32'h0) begin
      errors++; $display("[TB] FAIL async_reset got wait=%b ready=%b wr=%b rd=%h want all 0", pcpi_wait, pcpi_ready, pcpi_wr, pcpi_rd);
    end
    pcpi_valid = 1'b0;
    @(negedge clk);
    resetn = 1'b1;
    do_op(mk_insn(7'b0000001, F_DIVU), 32'd100, 32'd7, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'd14) begin errors++; $display("[TB] FAIL divu_after_reset got %h want e", rd); end
    checks++; if (k !== 33) begin errors++; $display("[TB] FAIL divu_after_reset_latency got %0d want 33", k); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] rd; int k, w; logic wr, wr_wait;
    do_op(mk_insn(7'b0000001, F_REMU), 32'd100, 32'd7, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'd2) begin errors++; $display("[TB] FAIL b2b_first got %h want 2", rd); end
    do_op(mk_insn(7'b0000001, F_DIV), 32'hFFFF_FF9C, 32'd7, rd, k, w, wr, wr_wait);
    checks++; if (rd !== 32'hFFFF_FFF2) begin errors++; $display("[TB] FAIL b2b_second got %h want fffffff2", rd); end
    checks++; if (k !== 33) begin errors++; $display("[TB] FAIL b2b_latency got %0d want 33", k); end
  endtask

  initial begin
    test_reset();
    test_signed();
    test_unsigned();
    test_div_zero();
    test_overflow();
    test_no_match();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
